// File: rtl/vxe_axi_switch_rsched.sv
// Response scheduler: weighted round-robin between the write- and read-response queues,
// popping the granted queue and registering the outgoing status/data strobes.
module vxe_axi_switch_rsched #(
    parameter int unsigned WEIGHT_RD = 4,
    parameter int unsigned WEIGHT_WR = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_cfg_fixed,
    input  logic        i_wr_vld,
    input  logic [8:0]  i_wr_stat,
    output logic        o_wr_pop,
    input  logic        i_rd_vld,
    input  logic [8:0]  i_rd_stat,
    input  logic [63:0] i_rd_data,
    output logic        o_rd_pop,
    input  logic        i_m_rss_rdy,
    output logic [8:0]  o_m_rss,
    output logic        o_m_rss_wr,
    input  logic        i_m_rsd_rdy,
    output logic [63:0] o_m_rsd,
    output logic        o_m_rsd_wr
);

    typedef enum logic {S_RD, S_WR} phase_e;

    localparam logic [8:0] W_RD = 9'(WEIGHT_RD);
    localparam logic [8:0] W_WR = 9'(WEIGHT_WR);

    phase_e      phase_q, phase_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [8:0]  cnt_inc;
    logic        rd_el, wr_el;
    logic        grant_rd, grant_wr;

    logic [8:0]  rss_q;
    logic [63:0] rsd_q;
    logic        rss_wr_q, rsd_wr_q;

    // A read needs room in both master FIFOs; a write only produces status.
    assign rd_el   = i_rd_vld & i_m_rss_rdy & i_m_rsd_rdy;
    assign wr_el   = i_wr_vld & i_m_rss_rdy;
    assign cnt_inc = {1'b0, cnt_q} + 9'd1;

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        phase_d  = phase_q;
        cnt_d    = cnt_q;
        grant_rd = 1'b0;
        grant_wr = 1'b0;
        if (i_cfg_fixed) begin
            phase_d = S_RD;
            cnt_d   = '0;
            if (rd_el)      grant_rd = 1'b1;
            else if (wr_el) grant_wr = 1'b1;
        end else begin
            case (phase_q)
                S_RD: begin
                    if (rd_el) begin
                        grant_rd = 1'b1;
                        if (cnt_inc >= W_RD && i_wr_vld) begin
                            phase_d = S_WR;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = (cnt_inc >= W_RD) ? W_RD[7:0] : cnt_inc[7:0];
                        end
                    end else if (wr_el) begin
                        // Serving a write while reads are blocked restarts the read budget.
                        grant_wr = 1'b1;
                        cnt_d    = '0;
                    end
                end
                S_WR: begin
                    if (wr_el) begin
                        grant_wr = 1'b1;
                        if (cnt_inc >= W_WR) begin
                            phase_d = S_RD;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_inc[7:0];
                        end
                    end else if (rd_el) begin
                        grant_rd = 1'b1;
                        phase_d  = S_RD;
                        cnt_d    = 8'd1;
                    end
                end
                default: begin
                    phase_d = S_RD;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    assign o_rd_pop = grant_rd & ~rst;
    assign o_wr_pop = grant_wr & ~rst;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q  <= S_RD;
            cnt_q    <= '0;
            // NOTE: the datapath registers are reset too, since their value is visible on the ports.
            rss_q    <= '0;
            rsd_q    <= '0;
            rss_wr_q <= 1'b0;
            rsd_wr_q <= 1'b0;
        end else begin
            phase_q  <= phase_d;
            cnt_q    <= cnt_d;
            rss_wr_q <= grant_rd | grant_wr;
            rsd_wr_q <= grant_rd;
            if (grant_rd) begin
                rss_q <= i_rd_stat;
                rsd_q <= i_rd_data;
            end else if (grant_wr) begin
                rss_q <= i_wr_stat;
            end
        end
    end

    assign o_m_rss    = rss_q;
    assign o_m_rsd    = rsd_q;
    assign o_m_rss_wr = rss_wr_q;
    assign o_m_rsd_wr = rsd_wr_q;

endmodule

// File: tb/tb_vxe_axi_switch_rsched.sv
// Bench for vxe_axi_switch_rsched: modelled source queues, a response scoreboard,
// and per-scenario grant-sequence checks.
module tb_vxe_axi_switch_rsched;

    typedef struct {
        logic [8:0]  stat;
        logic [63:0] data;
    } ent_t;

    typedef struct {
        bit          is_rd;
        logic [8:0]  stat;
        logic [63:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_cfg_fixed;
    logic        i_wr_vld;
    logic [8:0]  i_wr_stat;
    logic        o_wr_pop;
    logic        i_rd_vld;
    logic [8:0]  i_rd_stat;
    logic [63:0] i_rd_data;
    logic        o_rd_pop;
    logic        i_m_rss_rdy;
    logic [8:0]  o_m_rss;
    logic        o_m_rss_wr;
    logic        i_m_rsd_rdy;
    logic [63:0] o_m_rsd;
    logic        o_m_rsd_wr;

    ent_t        rd_q[$];
    ent_t        wr_q[$];
    exp_t        sb[$];
    logic [8:0]  exp_rss;
    logic [63:0] exp_rsd;
    string       trace;
    int          n_cmp = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    vxe_axi_switch_rsched #(.WEIGHT_RD(4), .WEIGHT_WR(1)) dut (
        .clk         (clk),
        .rst         (rst),
        .i_cfg_fixed (i_cfg_fixed),
        .i_wr_vld    (i_wr_vld),
        .i_wr_stat   (i_wr_stat),
        .o_wr_pop    (o_wr_pop),
        .i_rd_vld    (i_rd_vld),
        .i_rd_stat   (i_rd_stat),
        .i_rd_data   (i_rd_data),
        .o_rd_pop    (o_rd_pop),
        .i_m_rss_rdy (i_m_rss_rdy),
        .o_m_rss     (o_m_rss),
        .o_m_rss_wr  (o_m_rss_wr),
        .i_m_rsd_rdy (i_m_rsd_rdy),
        .o_m_rsd     (o_m_rsd),
        .o_m_rsd_wr  (o_m_rsd_wr)
    );

    task automatic load(input int n_rd, input int n_wr);
        for (int i = 0; i < n_rd; i++) rd_q.push_back('{9'($urandom), {$urandom, $urandom}});
        for (int i = 0; i < n_wr; i++) wr_q.push_back('{9'($urandom), 64'd0});
    endtask

    // One clock: drive queue heads, observe pops, then check the registered response.
    task automatic cycle();
        logic p_rd, p_wr;
        exp_t e;
        i_rd_vld  = (rd_q.size() != 0);
        i_rd_stat = (rd_q.size() != 0) ? rd_q[0].stat : 9'd0;
        i_rd_data = (rd_q.size() != 0) ? rd_q[0].data : 64'd0;
        i_wr_vld  = (wr_q.size() != 0);
        i_wr_stat = (wr_q.size() != 0) ? wr_q[0].stat : 9'd0;
        #1;
        p_rd = o_rd_pop;
        p_wr = o_wr_pop;
        n_cmp++;
        if ((p_rd & p_wr) !== 1'b0) begin
            n_fail++;
            $display("FAIL pop_excl: rd_pop=%b wr_pop=%b, required not both 1", p_rd, p_wr);
        end
        n_cmp++;
        if ((p_rd === 1'b1 && (!i_rd_vld || !i_m_rsd_rdy || !i_m_rss_rdy || rst)) ||
            (p_wr === 1'b1 && (!i_wr_vld || !i_m_rss_rdy || rst))) begin
            n_fail++;
            $display("FAIL pop_legal: rd_pop=%b wr_pop=%b rd_vld=%b wr_vld=%b rss_rdy=%b rsd_rdy=%b rst=%b",
                     p_rd, p_wr, i_rd_vld, i_wr_vld, i_m_rss_rdy, i_m_rsd_rdy, rst);
        end
        if (p_rd === 1'b1) begin
            sb.push_back('{1'b1, rd_q[0].stat, rd_q[0].data});
            void'(rd_q.pop_front());
            trace = {trace, "R"};
        end else if (p_wr === 1'b1) begin
            sb.push_back('{1'b0, wr_q[0].stat, 64'd0});
            void'(wr_q.pop_front());
            trace = {trace, "W"};
        end else begin
            trace = {trace, "-"};
        end
        @(posedge clk);
        #1;
        if (rst) begin
            sb.delete();
            exp_rss = '0;
            exp_rsd = '0;
            n_cmp++;
            if ({o_m_rss_wr, o_m_rsd_wr, o_m_rss, o_m_rsd} !== 75'd0) begin
                n_fail++;
                $display("FAIL reset_out: rss_wr=%b rsd_wr=%b rss=%h rsd=%h, required all 0",
                         o_m_rss_wr, o_m_rsd_wr, o_m_rss, o_m_rsd);
            end
        end else if (sb.size() != 0) begin
            e = sb.pop_front();
            exp_rss = e.stat;
            if (e.is_rd) exp_rsd = e.data;
            n_cmp++;
            if (o_m_rss_wr !== 1'b1 || o_m_rsd_wr !== e.is_rd || o_m_rss !== exp_rss || o_m_rsd !== exp_rsd) begin
                n_fail++;
                $display("FAIL resp: rss_wr=%b rsd_wr=%b rss=%h rsd=%h, required 1 %b %h %h",
                         o_m_rss_wr, o_m_rsd_wr, o_m_rss, o_m_rsd, e.is_rd, exp_rss, exp_rsd);
            end
        end else begin
            n_cmp++;
            if (o_m_rss_wr !== 1'b0 || o_m_rsd_wr !== 1'b0 || o_m_rss !== exp_rss || o_m_rsd !== exp_rsd) begin
                n_fail++;
                $display("FAIL idle_hold: rss_wr=%b rsd_wr=%b rss=%h rsd=%h, required 0 0 %h %h",
                         o_m_rss_wr, o_m_rsd_wr, o_m_rss, o_m_rsd, exp_rss, exp_rsd);
            end
        end
    endtask

    task automatic do_reset();
        rd_q.delete();
        wr_q.delete();
        i_cfg_fixed = 1'b0;
        i_m_rss_rdy = 1'b1;
        i_m_rsd_rdy = 1'b1;
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        trace = "";
    endtask

    task automatic test_reset();
        rst = 1'b1;
        i_cfg_fixed = 1'b0;
        i_m_rss_rdy = 1'b1;
        i_m_rsd_rdy = 1'b1;
        trace = "";
        cycle();
        cycle();
        rst = 1'b0;
        cycle();
        n_cmp++;
        if (trace != "---") begin
            n_fail++;
            $display("FAIL reset_trace: got %s, required ---", trace);
        end
    endtask

    task automatic test_reads_only();
        do_reset();
        load(6, 0);
        repeat (7) cycle();
        n_cmp++;
        if (trace != "RRRRRR-") begin
            n_fail++;
            $display("FAIL reads_only: got %s, required RRRRRR-", trace);
        end
    endtask

    task automatic test_wrr();
        string exp_tr;
        int nr, nw;
        do_reset();
        load(30, 30);
        repeat (20) cycle();
        exp_tr = "";
        for (int i = 0; i < 20; i++) exp_tr = {exp_tr, (i % 5 == 4) ? "W" : "R"};
        nr = 0;
        nw = 0;
        for (int i = 0; i < trace.len(); i++) begin
            if (trace[i] == "R") nr++;
            if (trace[i] == "W") nw++;
        end
        n_cmp++;
        if (trace != exp_tr) begin
            n_fail++;
            $display("FAIL wrr_seq: got %s, required %s", trace, exp_tr);
        end
        n_cmp++;
        if (nr != 16 || nw != 4) begin
            n_fail++;
            $display("FAIL wrr_count: got %0d reads %0d writes, required 16 4", nr, nw);
        end
    endtask

    task automatic test_rsd_block();
        do_reset();
        load(10, 10);
        i_m_rsd_rdy = 1'b0;
        repeat (6) cycle();
        i_m_rsd_rdy = 1'b1;
        cycle();
        n_cmp++;
        if (trace != "WWWWWWR") begin
            n_fail++;
            $display("FAIL rsd_block: got %s, required WWWWWWR", trace);
        end
    endtask

    task automatic test_fixed();
        do_reset();
        i_cfg_fixed = 1'b1;
        load(10, 5);
        repeat (10) cycle();
        n_cmp++;
        if (trace != "RRRRRRRRRR") begin
            n_fail++;
            $display("FAIL fixed_reads: got %s, required RRRRRRRRRR", trace);
        end
        trace = "";
        cycle();
        n_cmp++;
        if (trace != "W") begin
            n_fail++;
            $display("FAIL fixed_fallback: got %s, required W", trace);
        end
        i_cfg_fixed = 1'b0;
    endtask

    task automatic test_rss_block();
        do_reset();
        load(5, 5);
        repeat (2) cycle();
        i_m_rss_rdy = 1'b0;
        repeat (4) cycle();
        i_m_rss_rdy = 1'b1;
        cycle();
        n_cmp++;
        if (trace != "RR----R") begin
            n_fail++;
            $display("FAIL rss_block: got %s, required RR----R", trace);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        load(20, 20);
        repeat (2) cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        repeat (5) cycle();
        n_cmp++;
        if (trace != "RR-RRRRW") begin
            n_fail++;
            $display("FAIL reset_mid: got %s, required RR-RRRRW", trace);
        end
    endtask

    initial begin
        rst = 1'b1;
        i_cfg_fixed = 1'b0;
        i_m_rss_rdy = 1'b1;
        i_m_rsd_rdy = 1'b1;
        i_wr_vld = 1'b0;
        i_wr_stat = '0;
        i_rd_vld = 1'b0;
        i_rd_stat = '0;
        i_rd_data = '0;
        exp_rss = '0;
        exp_rsd = '0;
        test_reset();
        test_reads_only();
        test_wrr();
        test_rsd_block();
        test_fixed();
        test_rss_block();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/vxe_axi_switch_rsched.md
# vxe_axi_switch_rsched

Response scheduler for the VxE AXI switch downstream path. Arbitrates between the write-response queue and the read-response queue and drives the master response status (rss) and response data (rsd) ports. Arbitration is a weighted round-robin with configurable weights and an optional fixed read-priority mode. It pops the granted queue and registers the outgoing response, replacing the unconditional read-over-write priority used so far.

## Interface
- WEIGHT_RD, 4: max consecutive read grants while a write is pending; range 1..255.
- WEIGHT_WR, 1: max consecutive write grants while in write phase; range 1..255.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- i_cfg_fixed  in  1  1 = fixed read priority, weights ignored.
- i_wr_vld  in  1  write-response queue non-empty.
- i_wr_stat  in  9  coded write-response status at queue head.
- o_wr_pop  out  1  pop write queue this cycle (combinational).
- i_rd_vld  in  1  read-response queue non-empty.
- i_rd_stat  in  9  coded read-response status at queue head.
- i_rd_data  in  64  read data at queue head.
- o_rd_pop  out  1  pop read queue this cycle (combinational).
- i_m_rss_rdy  in  1  master status FIFO can accept one entry.
- o_m_rss  out  9  response status.
- o_m_rss_wr  out  1  status write strobe.
- i_m_rsd_rdy  in  1  master data FIFO can accept one entry.
- o_m_rsd  out  64  response data.
- o_m_rsd_wr  out  1  data write strobe.

## Operation
- Eligibility:
  - rd_el = i_rd_vld & i_m_rss_rdy & i_m_rsd_rdy.
  - wr_el = i_wr_vld & i_m_rss_rdy.
- State: phase ∈ {S_RD, S_WR}; cnt is 8-bit. Reset: S_RD, cnt=0.
- Fixed mode (i_cfg_fixed=1):
  - Grant read if rd_el, else write if wr_el.
  - phase/cnt forced to S_RD/0.
- S_RD:
  - If rd_el, grant read:
    - if cnt+1 ≥ WEIGHT_RD and i_wr_vld: go to S_WR, cnt←0;
    - else cnt←min(cnt+1, WEIGHT_RD), stay in S_RD.
  - Else if wr_el: grant write, cnt←0, stay in S_RD (work-conserving; write service resets read budget).
- S_WR:
  - If wr_el, grant write:
    - if cnt+1 ≥ WEIGHT_WR: go to S_RD, cnt←0;
    - else cnt←cnt+1.
  - Else if rd_el: grant read, go to S_RD, cnt←1.
- Neither eligible: no grant; phase and cnt hold.
- Grant read:
  - o_rd_pop=1.
  - Next cycle: o_m_rss←i_rd_stat, o_m_rsd←i_rd_data, o_m_rss_wr=1, o_m_rsd_wr=1.
- Grant write:
  - o_wr_pop=1.
  - Next cycle: o_m_rss←i_wr_stat, o_m_rss_wr=1, o_m_rsd_wr=0, o_m_rsd unchanged.
- Pop exclusivity: o_rd_pop and o_wr_pop are never both 1.
- A pop is never asserted when its queue's vld is 0.
- A read is never granted with i_m_rsd_rdy=0.
- A write may be granted with i_m_rsd_rdy=0.

## Timing
- Reset values: o_m_rss=0, o_m_rsd=0, o_m_rss_wr=0, o_m_rsd_wr=0, phase=S_RD, cnt=0.
- Pops forced 0 while rst=1.
- Reset mid-stream: the grant in the reset cycle is suppressed; no strobe follows it.
- Grant latency: vld/rdy sampled in cycle N; pop asserted in cycle N (combinational); strobe and data registered at the end of N, visible in N+1.
- Strobes are single-cycle pulses. o_m_rss/o_m_rsd hold their last value when no strobe.
- Throughput: one response per cycle, no bubbles between back-to-back grants.
- rdy contract: i_m_*_rdy=1 guarantees space for the one entry written in N+1. The registered write in N+1 is already accounted for by the downstream FIFO's pre-full margin.
- Queue contract: the queue advances its head on the pop edge. i_*_stat/i_rd_data are valid whenever the matching vld=1.

## Test plan
- Reads only: 6 read entries, both rdy=1, defaults → o_rd_pop on 6 consecutive cycles; 6 consecutive rss_wr/rsd_wr pulses one cycle later with matching stat/data; o_wr_pop never set.
- Both queues continuously valid, WEIGHT_RD=4, WEIGHT_WR=1, fixed=0 → grant sequence R,R,R,R,W repeating; after 20 cycles exactly 16 reads and 4 writes.
- Both valid, i_m_rsd_rdy=0, i_m_rss_rdy=1 → only writes granted each cycle; o_m_rsd_wr stays 0. Raising rsd_rdy resumes reads in the same cycle.
- i_cfg_fixed=1, both valid for 10 cycles → 10 reads, 0 writes. Drop i_rd_vld → a write is granted that same cycle.
- i_m_rss_rdy=0 with both valid → no pops and no strobes; o_m_rss/o_m_rsd hold their prior values.
- rst=1 for one cycle after 2 reads in S_RD → pops 0 in that cycle, all outputs 0 next cycle. After release with both valid: 4 reads then 1 write (cnt restarted from 0).
